// File: rtl/uart_rx_fifo.sv
// UART receiver: majority-vote oversampling, 5-8 data bits, optional parity,
// 1/2 stop bits, break detection, FWFT character FIFO and RTS flow control.
module uart_rx_fifo #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned RTS_LEVEL  = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_tick,
  input  logic [1:0]                    data_bit_num_i,
  input  logic                          parity_en_i,
  input  logic                          parity_type_i,
  input  logic                          stop_bit_num_i,
  input  logic                          host_read_data_i,
  input  logic                          clear_err_i,
  input  logic                          rx_i,
  output logic                          rts_n_o,
  output logic                          rx_valid_o,
  output logic [31:0]                   rx_data_o,
  output logic                          parity_error_o,
  output logic                          framing_error_o,
  output logic                          break_o,
  output logic                          overrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [CW-1:0] SMP0  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] SMP1  = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] SMP2  = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] CLAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  typedef struct packed {
    logic       brk;
    logic       frm;
    logic       par;
    logic [7:0] data;
  } entry_t;

  state_t          state, state_d;
  logic [1:0]      sync;
  logic            rx_s, rx_prev, fall;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic            stop_idx;
  logic [7:0]      shreg;
  logic            smp0, smp1, par_bit, frm_err;
  logic [1:0]      cfg_bits;
  logic            cfg_pen, cfg_ptype, cfg_stop2;
  logic            at_s0, at_s1, at_s2, at_end, maj;
  logic            last_bit, last_stop, zero_so_far, brk_c, done_c, perr_c;
  logic            push;
  entry_t          push_entry;

  entry_t          mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic            full, empty, pop, wr_en, drop;
  entry_t          head;

  assign rx_s   = sync[1];
  assign fall   = rx_prev & ~rx_s;
  assign at_s0  = rx_tick && (cnt == SMP0);
  assign at_s1  = rx_tick && (cnt == SMP1);
  assign at_s2  = rx_tick && (cnt == SMP2);
  assign at_end = rx_tick && (cnt == CLAST);
  assign maj    = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);

  assign last_bit    = (bit_idx == (3'(cfg_bits) + 3'd4));
  assign last_stop   = (stop_idx == cfg_stop2);
  assign zero_so_far = (shreg == 8'h00) && !(cfg_pen && par_bit);
  assign brk_c       = (state == STOP) && !stop_idx && at_s2 && !maj && zero_so_far;
  assign done_c      = (state == STOP) && at_s2 && last_stop && !brk_c;
  assign perr_c      = cfg_pen && (par_bit != (cfg_ptype ? ^shreg : ~^shreg));

  // Receive FSM next-state
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:      if (fall) state_d = START;
      START: begin
        if (at_s2 && maj)  state_d = IDLE;
        else if (at_end)   state_d = DATA;
      end
      DATA:      if (at_end && last_bit) state_d = cfg_pen ? PARITY : STOP;
      PARITY:    if (at_end) state_d = STOP;
      STOP: begin
        if (brk_c)         state_d = WAIT_HIGH;
        else if (done_c)   state_d = IDLE;
      end
      WAIT_HIGH: if (at_end && rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Synchroniser, bit timing and frame assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync       <= 2'b11;
      rx_prev    <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      smp0       <= 1'b1;
      smp1       <= 1'b1;
      par_bit    <= 1'b0;
      frm_err    <= 1'b0;
      cfg_bits   <= 2'b11;
      cfg_pen    <= 1'b0;
      cfg_ptype  <= 1'b0;
      cfg_stop2  <= 1'b0;
      push       <= 1'b0;
      push_entry <= '0;
    end else begin
      sync    <= {sync[0], rx_i};
      rx_prev <= rx_s;
      push    <= brk_c | done_c;

      if (state == IDLE)                           cnt <= '0;
      else if (state == WAIT_HIGH && !rx_s)        cnt <= '0;
      else if (state_d == WAIT_HIGH && state == STOP) cnt <= '0;
      else if (rx_tick)                            cnt <= (cnt == CLAST) ? '0 : cnt + CW'(1);

      if (at_s0) smp0 <= rx_s;
      if (at_s1) smp1 <= rx_s;

      if (state == IDLE && fall) begin
        cfg_bits  <= data_bit_num_i;
        cfg_pen   <= parity_en_i;
        cfg_ptype <= parity_type_i;
        cfg_stop2 <= stop_bit_num_i;
        shreg     <= '0;
        bit_idx   <= '0;
        stop_idx  <= 1'b0;
        frm_err   <= 1'b0;
        par_bit   <= 1'b0;
      end

      if (state == DATA && at_s2)   shreg[bit_idx] <= maj;
      if (state == DATA && at_end)  bit_idx <= bit_idx + 3'd1;
      if (state == PARITY && at_s2) par_bit <= maj;
      if (state == STOP && at_s2 && !maj) frm_err <= 1'b1;
      if (state == STOP && at_end)  stop_idx <= 1'b1;

      if (brk_c)       push_entry <= '{brk: 1'b1, frm: 1'b1, par: 1'b0, data: 8'h00};
      else if (done_c) push_entry <= '{brk: 1'b0, frm: frm_err | ~maj, par: perr_c, data: shreg};
    end
  end

  assign full  = (level == LW'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign pop   = host_read_data_i && !empty;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_entry;
  end

  // FIFO pointers, level, sticky overrun and RTS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overrun_o <= 1'b0;
      rts_n_o   <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)      level <= level + LW'(1);
      else if (pop && !wr_en) level <= level - LW'(1);
      if (drop)             overrun_o <= 1'b1;
      else if (clear_err_i) overrun_o <= 1'b0;
      rts_n_o <= (level >= LW'(RTS_LEVEL));
    end
  end

  assign head            = mem[rd_ptr];
  assign rx_valid_o      = !empty;
  assign rx_data_o       = empty ? 32'h0 : 32'(head.data);
  assign parity_error_o  = !empty && head.par;
  assign framing_error_o = !empty && head.frm;
  assign break_o         = !empty && head.brk;
  assign fifo_level_o    = level;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Second-generation UART receiver for the APB-UART peripheral. It oversamples the serial line with majority voting, frames 5–8 data bits with optional parity and 1/2 stop bits, and flags parity, framing and break conditions per character. Received characters are buffered in a parametrised first-word-fall-through FIFO. RTS flow control is driven from the FIFO fill level.

Parameters:
OVERSAMPLE, 16, rx_tick pulses per bit period; even, ≥8
FIFO_DEPTH, 16, number of FIFO entries; power of two, ≥2
RTS_LEVEL, 12, fill level at or above which rts_n_o deasserts (1); 1..FIFO_DEPTH

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
rx_tick  input  1  oversample enable from baud generator
data_bit_num_i  input  2  00=5, 01=6, 10=7, 11=8 data bits
parity_en_i  input  1  1=parity bit present
parity_type_i  input  1  1=even, 0=odd
stop_bit_num_i  input  1  0=one stop bit, 1=two stop bits
host_read_data_i  input  1  pop FIFO head (ignored when empty)
clear_err_i  input  1  clears sticky overrun_o
rx_i  input  1  serial line (asynchronous)
rts_n_o  output  1  request-to-send, active-low
rx_valid_o  output  1  FIFO not empty
rx_data_o  output  32  head data, zero-extended to the configured width
parity_error_o  output  1  head entry parity error
framing_error_o  output  1  head entry framing error
break_o  output  1  head entry is a break
overrun_o  output  1  sticky: a character was dropped because the FIFO was full
fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current entry count

Behaviour:
- rx_i passes through a 2-flop synchroniser, reset value 1. All sampling uses the synchronised value.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. The tick counter advances only on rx_tick and wraps at OVERSAMPLE-1.
- IDLE:
  - A 1→0 transition on the synchronised line clears the counter, enters START, and latches all config inputs.
  - Config changes mid-frame have no effect until the next start bit.
- Bit value = majority of the three samples at counter values OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- START:
  - If the majority is 1 at OVERSAMPLE/2+1, it is a false start: return to IDLE with no push.
  - Otherwise continue to DATA at the end of the bit period.
- DATA: receives N bits, LSB first. PARITY is entered only if parity_en latched = 1.
- Parity error is set when the received parity bit differs from the expected value:
  - even: XOR of the data bits;
  - odd: its inverse.
- STOP:
  - Each stop bit is sampled mid-bit; any 0 sets the framing error.
  - The push occurs in the cycle after the last stop bit's third sample, and the FSM returns to IDLE immediately (half-bit resync margin).
- Break:
  - Detected when all data bits, the parity bit (if present) and the first stop bit are 0.
  - Push data=0 with break=1, framing=1 and parity error forced to 0, then enter WAIT_HIGH until the synchronised line is 1 for one full bit period, then go to IDLE.
- FIFO:
  - Entry = {break, framing, parity, data[7:0]}. Head is visible combinationally (FWFT).
  - Pop happens on host_read_data_i && rx_valid_o.
  - Simultaneous push and pop: both take effect, level unchanged, including when full.
  - Push while full without pop: character dropped and overrun_o set. overrun_o clears on clear_err_i; a set in the same cycle as clear has priority.
  - Pointers wrap modulo FIFO_DEPTH.
- rts_n_o is registered: rts_n_o = (fifo_level ≥ RTS_LEVEL). It updates one cycle after a level change.
- Empty FIFO: rx_data_o=0 and all head flags = 0.
- Reset values (any time, including mid-frame): FSM=IDLE, FIFO emptied, rx_valid_o=0, rx_data_o=0, all flags=0, fifo_level_o=0, rts_n_o=1. rts_n_o falls to 0 on the first clock after rst deasserts.

Test Plan:
- 8N1, byte 0xA5, OVERSAMPLE=16 → one push, rx_data_o=0x000000A5, rx_valid_o=1, no flags; pop → rx_valid_o=0, level=0.
- 7E2, data 0x35 with parity bit 1 (wrong; correct is 0) → push 0x35, parity_error_o=1, framing_error_o=0.
- 0.25-bit low glitch on idle line → no push, FSM back in IDLE; a 1-tick glitch inside a data-bit mid-window → majority voting still yields the correct byte.
- 8N1 line held low for 20 bit times → one entry with data=0, break_o=1, framing_error_o=1. No further pushes until the line is high for 1 bit, then a following 0x55 is received correctly.
- FIFO_DEPTH=16, RTS_LEVEL=12, 17 bytes with no pops:
  - rts_n_o=1 one cycle after the 12th push;
  - the 17th byte is dropped and overrun_o=1, level=16;
  - clear_err_i → overrun_o=0;
  - 5 pops → level=11 and rts_n_o=0.
- rst asserted mid-DATA with 3 entries queued → all outputs at reset values; the next clean 0x3C frame is received correctly.
